// File: rtl/linear_proj_pkg.sv
// Shared sizing constants and controller state encoding for the linear projection datapath.
// Pure declarations: no latency and no flow-control behaviour.
// Consumers import this package; nothing here holds state.
package linear_proj_pkg;

    localparam int ROW_SIZE_MAT_C  = 2;
    localparam int COL_SIZE_MAT_C  = 3;
    localparam int INNER_DIMENSION = 48;
    localparam int BLOCK_SIZE      = 16;
    localparam int MAX_FLAG        = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
    localparam int ADDR_WIDTH_A    = 8;
    localparam int ADDR_WIDTH_B    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT_DONE,
        HANDOFF,
        FIN
    } ctrl_state_t;

endpackage

// File: rtl/linear_proj_tile_cnt.sv
// Nested inner-step / tile-column / tile-row counter for the projection controller.
// Latency: counts update on the clock edge after k_inc / tile_inc.
// Backpressure: none of its own; the controller only pulses k_inc and tile_inc when a transfer happens.
module linear_proj_tile_cnt #(
    parameter int ROW_TILES   = 2,
    parameter int COL_TILES   = 3,
    parameter int INNER_STEPS = 3,
    parameter int RW          = 1,
    parameter int CW          = 2,
    parameter int KW          = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          k_inc,
    input  logic          tile_inc,
    output logic [KW-1:0] k,
    output logic [RW-1:0] tile_row,
    output logic [CW-1:0] tile_col,
    output logic          k_last,
    output logic          tile_last
);

    logic col_last;
    logic row_last;

    assign k_last    = (k == KW'(INNER_STEPS - 1));
    assign col_last  = (tile_col == CW'(COL_TILES - 1));
    assign row_last  = (tile_row == RW'(ROW_TILES - 1));
    assign tile_last = col_last && row_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            tile_row <= '0;
            tile_col <= '0;
        end else if (clr) begin
            k        <= '0;
            tile_row <= '0;
            tile_col <= '0;
        end else begin
            if (k_inc) begin
                k <= k_last ? '0 : k + KW'(1);
            end
            // Column is the fast index; the row only moves when the column wraps.
            if (tile_inc) begin
                if (col_last) begin
                    tile_col <= '0;
                    tile_row <= row_last ? '0 : tile_row + RW'(1);
                end else begin
                    tile_col <= tile_col + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/linear_proj_ctrl.sv
// Tile sequencer: streams A/B BRAM reads into the matmul, then hands each tile to writeback (optional LINEAR_PROJ_CTRL_PERF_EN busy-cycle counter).
// Latency: first read one cycle after start; mm_valid/first/last trail rd_en by one cycle.
// Backpressure: reads issue only while mm_ready=1; tile handoff holds out_valid until out_ready.
module linear_proj_ctrl #(
    parameter int ROW_TILES    = linear_proj_pkg::ROW_SIZE_MAT_C,
    parameter int COL_TILES    = linear_proj_pkg::COL_SIZE_MAT_C,
    parameter int INNER_STEPS  = linear_proj_pkg::INNER_DIMENSION / linear_proj_pkg::BLOCK_SIZE,
    parameter int ADDR_WIDTH_A = linear_proj_pkg::ADDR_WIDTH_A,
    parameter int ADDR_WIDTH_B = linear_proj_pkg::ADDR_WIDTH_B
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en_a,
    output logic [ADDR_WIDTH_A-1:0] rd_addr_a,
    output logic                    rd_en_b,
    output logic [ADDR_WIDTH_B-1:0] rd_addr_b,
    input  logic                    mm_ready,
    output logic                    mm_valid,
    output logic                    mm_first,
    output logic                    mm_last,
    input  logic                    mm_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2((ROW_TILES < 2) ? 2 : ROW_TILES)-1:0] tile_row,
    output logic [$clog2((COL_TILES < 2) ? 2 : COL_TILES)-1:0] tile_col,
    output logic [$clog2(linear_proj_pkg::MAX_FLAG + 1)-1:0]   flag_cnt,
    output logic [31:0]             perf_cycles
);

    import linear_proj_pkg::*;

    localparam int RW = $clog2((ROW_TILES < 2) ? 2 : ROW_TILES);
    localparam int CW = $clog2((COL_TILES < 2) ? 2 : COL_TILES);
    localparam int KW = $clog2((INNER_STEPS < 2) ? 2 : INNER_STEPS);
    localparam int FW = $clog2(MAX_FLAG + 1);

    ctrl_state_t   state;
    ctrl_state_t   state_nxt;
    logic [KW-1:0] k;
    logic          k_last;
    logic          tile_last;
    logic          issue;
    logic          accept;
    logic          tile_inc;

    linear_proj_tile_cnt #(
        .ROW_TILES   (ROW_TILES),
        .COL_TILES   (COL_TILES),
        .INNER_STEPS (INNER_STEPS),
        .RW          (RW),
        .CW          (CW),
        .KW          (KW)
    ) u_tile_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .k_inc     (issue),
        .tile_inc  (tile_inc),
        .k         (k),
        .tile_row  (tile_row),
        .tile_col  (tile_col),
        .k_last    (k_last),
        .tile_last (tile_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        tile_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = FEED;
                end
            end
            FEED: begin
                if (mm_ready) begin
                    issue = 1'b1;
                    if (k_last) begin
                        state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (mm_done) begin
                    state_nxt = HANDOFF;
                end
            end
            HANDOFF: begin
                if (out_ready) begin
                    tile_inc  = 1'b1;
                    state_nxt = tile_last ? FIN : FEED;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign out_valid = (state == HANDOFF);
    assign rd_en_a   = issue;
    assign rd_en_b   = issue;
    assign rd_addr_a = ADDR_WIDTH_A'(tile_row) * ADDR_WIDTH_A'(INNER_STEPS) + ADDR_WIDTH_A'(k);
    assign rd_addr_b = ADDR_WIDTH_B'(tile_col) * ADDR_WIDTH_B'(INNER_STEPS) + ADDR_WIDTH_B'(k);

    // Beat markers are delayed one cycle to line up with the BRAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_valid <= 1'b0;
            mm_first <= 1'b0;
            mm_last  <= 1'b0;
        end else begin
            mm_valid <= issue;
            mm_first <= issue && (k == '0);
            mm_last  <= issue && k_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_cnt <= '0;
        end else if (accept) begin
            flag_cnt <= '0;
        end else if (tile_inc) begin
            flag_cnt <= flag_cnt + FW'(1);
        end
    end

`ifdef LINEAR_PROJ_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_linear_proj_ctrl.sv
// Randomised and directed bench for linear_proj_ctrl against a beat-list reference model.
module tb_linear_proj_ctrl;

    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int INNER = 3;
    localparam int AW    = 8;
    localparam int DLY   = 2;
    localparam int TILES = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mm_ready = 1'b0;
    logic          mm_done = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, rd_en_a, rd_en_b, mm_valid, mm_first, mm_last, out_valid;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [0:0]    tile_row;
    logic [1:0]    tile_col;
    logic [2:0]    flag_cnt;
    logic [31:0]   perf_cycles;

    linear_proj_ctrl #(
        .ROW_TILES    (ROWS),
        .COL_TILES    (COLS),
        .INNER_STEPS  (INNER),
        .ADDR_WIDTH_A (AW),
        .ADDR_WIDTH_B (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_en_a     (rd_en_a),
        .rd_addr_a   (rd_addr_a),
        .rd_en_b     (rd_en_b),
        .rd_addr_b   (rd_addr_b),
        .mm_ready    (mm_ready),
        .mm_valid    (mm_valid),
        .mm_first    (mm_first),
        .mm_last     (mm_last),
        .mm_done     (mm_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .tile_row    (tile_row),
        .tile_col    (tile_col),
        .flag_cnt    (flag_cnt),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int k;
        int r;
        int c;
    } beat_t;

    beat_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int rdy_mode = 0;
    int ready_phase = 0;
    int stall_len = 0;
    int stall_left = 0;
    int dly_cnt = 0;
    bit start_req = 1'b0;
    bit inject_stray = 1'b0;
    bit prev_rd = 1'b0;
    int prev_k = -1;
    bit prev_ov = 1'b0;
    bit prev_or = 1'b0;
    bit prev_done = 1'b0;
    int exp_flag = 0;
    int busy_seen = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference beat list: row-major tiles, column fastest, k innermost.
    task automatic build_model();
        beat_t e;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int k = 0; k < INNER; k++) begin
                    e.a = r * INNER + k;
                    e.b = c * INNER + k;
                    e.k = k;
                    e.r = r;
                    e.c = c;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Drive inputs on the falling edge, sample outputs 1ns later, then advance the model.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            start     = start_req;
            start_req = 1'b0;
            case (rdy_mode)
                1:       begin mm_ready = (ready_phase % 2 == 0); ready_phase++; end
                2:       mm_ready = 1'($urandom_range(0, 1));
                default: mm_ready = 1'b1;
            endcase
            mm_done = 1'b0;
            if (!rst_n) begin
                dly_cnt = 0;
            end else if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0) mm_done = 1'b1;
            end
            if (inject_stray && mm_valid && !mm_first && !mm_last) begin
                mm_done      = 1'b1;
                inject_stray = 1'b0;
            end
            if (out_valid && !prev_ov) stall_left = stall_len;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            if (!rst_n) begin
                prev_rd   = 1'b0;
                prev_k    = -1;
                prev_ov   = 1'b0;
                prev_or   = 1'b0;
                prev_done = 1'b0;
                exp_flag  = 0;
                stall_left = 0;
            end else begin
                if (!mm_ready) chk("rd_en_without_ready", rd_en_a | rd_en_b, 0);
                if (out_valid) chk("rd_en_in_handoff", rd_en_a | rd_en_b, 0);
                if (prev_ov && !prev_or) chk("out_valid_hold", out_valid, 1);
                chk("mm_valid", mm_valid, prev_rd);
                chk("mm_first", mm_first, prev_rd && prev_k == 0);
                chk("mm_last", mm_last, prev_rd && prev_k == INNER - 1);
                chk("flag_cnt", flag_cnt, exp_flag);
                if (done) chk("done_width", prev_done, 0);
                prev_k = -1;
                if (rd_en_a || rd_en_b) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", rd_en_a | rd_en_b, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_en_a", rd_en_a, 1);
                        chk("rd_en_b", rd_en_b, 1);
                        chk("rd_addr_a", rd_addr_a, e.a);
                        chk("rd_addr_b", rd_addr_b, e.b);
                        chk("tile_row", tile_row, e.r);
                        chk("tile_col", tile_col, e.c);
                        prev_k = e.k;
                    end
                end
                if (mm_last) dly_cnt = DLY;
                if (busy) busy_seen++;
                if (done) done_seen++;
                prev_rd   = rd_en_a;
                prev_ov   = out_valid;
                prev_or   = out_ready;
                prev_done = done;
                if (out_valid && out_ready) exp_flag++;
                if (start && !busy) begin
                    exp_flag  = 0;
                    busy_seen = 0;
                end
            end
        end
    end

    task automatic run(input int mode, input int stall, input bit poke);
        int cyc;
        rdy_mode  = mode;
        stall_len = stall;
        build_model();
        done_seen = 0;
        start_req = 1'b1;
        cyc = 0;
        while (done_seen == 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            if (poke && cyc == 4) inject_stray = 1'b1;
            if (poke && cyc == 6) start_req = 1'b1;
        end
        chk("run_completes", cyc < 3000, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("done_pulses", done_seen, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("flag_final", flag_cnt, TILES);
        chk("busy_after_done", busy, 0);
        if (mode == 0) chk("busy_cycles", busy_seen, TILES * (INNER + DLY + 2 + stall) + 1);
`ifdef LINEAR_PROJ_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, busy_seen);
`else
        chk("perf_cycles", perf_cycles, 0);
`endif
        inject_stray = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, {rd_en_a, rd_en_b}, 0);
        chk({tag, "_addr"}, {rd_addr_a, rd_addr_b}, 0);
        chk({tag, "_mm"}, {mm_valid, mm_first, mm_last}, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_tile"}, {tile_row, tile_col}, 0);
        chk({tag, "_flag_cnt"}, flag_cnt, 0);
        chk({tag, "_perf"}, perf_cycles, 0);
    endtask

    task automatic reset_mid();
        int cyc;
        rdy_mode  = 0;
        stall_len = 0;
        build_model();
        done_seen = 0;
        start_req = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
            if (tile_col == 2'd1 && mm_valid) break;
        end
        chk("reach_second_tile", cyc < 200, 1);
        chk("flag_before_reset", flag_cnt, 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_rst");
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run(0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_idle_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run(0, 0, 0);
        run(1, 0, 0);
        run(0, 5, 0);
        run(0, 0, 1);
        reset_mid();
        run(2, 0, 0);
        run(2, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/linear_proj_ctrl.md
LINEAR_PROJ_CTRL -- requirements
Module: linear_proj_ctrl

Interface
REQ-001 SHALL have parameter ROW_TILES, default linear_proj_pkg::ROW_SIZE_MAT_C, meaning output-tile rows of matrix C.
REQ-002 SHALL have parameter COL_TILES, default linear_proj_pkg::COL_SIZE_MAT_C, meaning output-tile columns of matrix C.
REQ-003 SHALL have parameter INNER_STEPS, default INNER_DIMENSION/BLOCK_SIZE, meaning inner-dimension beats per tile.
REQ-004 SHALL have parameters ADDR_WIDTH_A and ADDR_WIDTH_B, defaults from linear_proj_pkg, meaning BRAM address widths.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, a one-cycle request that begins a full projection.
REQ-008 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse after the last tile is handed off.
REQ-010 SHALL have ports rd_en_a/rd_addr_a, output, 1/ADDR_WIDTH_A, the A BRAM read strobe and address.
REQ-011 SHALL have ports rd_en_b/rd_addr_b, output, 1/ADDR_WIDTH_B, the B BRAM read strobe and address.
REQ-012 SHALL have port mm_ready, input, 1, matmul can take a beat one cycle later.
REQ-013 SHALL have ports mm_valid/mm_first/mm_last, output, 1 each, the beat qualifier plus accumulator clear/finish markers.
REQ-014 SHALL have port mm_done, input, 1, the tile result is valid in the matmul.
REQ-015 SHALL have ports out_valid/out_ready, output/input, 1 each, the tile handoff handshake to the writeback.
REQ-016 SHALL have ports tile_row/tile_col, output, $clog2 of max(ROW_TILES,2)/max(COL_TILES,2), the current tile indices.
REQ-017 SHALL have port flag_cnt, output, $clog2(MAX_FLAG+1), the count of completed tiles.
REQ-018 SHALL have port perf_cycles, output, 32, the busy-cycle count.

Function
REQ-019 SHALL implement FSM states IDLE, FEED, WAIT_DONE, HANDOFF, FIN.
REQ-020 SHALL move IDLE->FEED on start; start in any other state is ignored.
REQ-021 SHALL, in FEED, issue rd_en_a=rd_en_b=1 only in cycles where mm_ready=1, each issue advancing inner index k.
REQ-022 SHALL drive rd_addr_a = tile_row*INNER_STEPS+k and rd_addr_b = tile_col*INNER_STEPS+k.
REQ-023 SHALL assert mm_valid exactly one cycle after each rd_en, covering BRAM read latency; mm_first SHALL mark k=0 and mm_last SHALL mark k=INNER_STEPS-1.
REQ-024 SHALL move FEED->WAIT_DONE after the k=INNER_STEPS-1 issue, and WAIT_DONE->HANDOFF on mm_done.
REQ-025 SHALL hold out_valid=1 in HANDOFF until out_ready=1; on that handshake flag_cnt SHALL increment.
REQ-026 SHALL advance tile_col first and wrap it to 0 while incrementing tile_row; after tile (ROW_TILES-1, COL_TILES-1) the FSM SHALL go to FIN, otherwise to FEED.
REQ-027 SHALL pulse done in FIN for 1 cycle, then return to IDLE with busy=0; flag_cnt SHALL hold until the next start, which clears it.
REQ-028 SHALL ignore mm_done outside WAIT_DONE.
REQ-029 SHALL issue the first rd_en no earlier than the cycle after start.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-tile, immediately force IDLE with all outputs 0, indices 0, flag_cnt 0 and perf_cycles 0.

Configuration
REQ-031 SHALL, with LINEAR_PROJ_CTRL_PERF_EN defined, increment perf_cycles every cycle busy=1, saturating at 2^32-1 and clearing on accepted start; without the macro, perf_cycles SHALL be constant 0 with no counter logic.

Structure
REQ-032 SHALL place the FSM state enum typedef in linear_proj_pkg alongside ROW_SIZE_MAT_C, COL_SIZE_MAT_C and MAX_FLAG.
REQ-033 SHALL factor the k/col/row nested counter as sub-module linear_proj_tile_cnt.

Verification
REQ-034 SHALL test ROW=2, COL=3, INNER=3 with mm_ready=1, mm_done 2 cycles after mm_last and out_ready=1: expect 18 beats, rd_addr_a sequence 0,1,2 x3 then 3,4,5 x3, rd_addr_b 0..8 per row, flag_cnt=6 and one done pulse.
REQ-035 SHALL test mm_ready toggled 1,0,1,0: rd_en SHALL follow mm_ready, with no skipped or duplicated k.
REQ-036 SHALL test out_ready held 0 for 5 cycles: out_valid SHALL stay high, and no rd_en or flag_cnt change SHALL occur until the handshake.
REQ-037 SHALL test rst_n pulsed low in the middle of the second tile: outputs SHALL go 0 asynchronously, and a new start SHALL restart from addr 0.
REQ-038 SHALL test start re-asserted while busy, plus a stray mm_done in FEED: neither SHALL have any effect.
REQ-039 SHALL test with PERF_EN on, the REQ-034 run at mm_ready=1: perf_cycles SHALL equal the busy-high cycle count; with PERF_EN off it SHALL read 0.
